// File: rtl/parking_gate_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : parking_gate_ctrl_if
// Purpose : Bundles the card reader, driver buttons, bookkeeping verdict flags
//           and the gate/lamp outputs of the parking gate sequencer.
// Revision: 1.0  initial release
// ============================================================================
interface parking_gate_ctrl_if;
  // reader / driver / sensor / bookkeeping verdict inputs
  logic       card_swiped;
  logic [1:0] mode_sel;
  logic       id_valid;
  logic       id_special;
  logic       chosen_flr_full;
  logic       alternative_flr_full;
  logic       accept_alt;
  logic       reject;
  logic       car_passed;
  // sequencer outputs
  logic [1:0] mode;
  logic [1:0] action_taken;
  logic       gate_open;
  logic       alt_offer;
  logic       deny;
  logic [1:0] deny_code;
  logic       busy;

  // environment side: reader, buttons, sensor and bookkeeping stage
  modport master (
    output card_swiped, mode_sel, id_valid, id_special, chosen_flr_full,
           alternative_flr_full, accept_alt, reject, car_passed,
    input  mode, action_taken, gate_open, alt_offer, deny, deny_code, busy
  );

  // sequencer side
  modport slave (
    input  card_swiped, mode_sel, id_valid, id_special, chosen_flr_full,
           alternative_flr_full, accept_alt, reject, car_passed,
    output mode, action_taken, gate_open, alt_offer, deny, deny_code, busy
  );
endinterface
`default_nettype wire

// File: rtl/parking_gate_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : parking_gate_ctrl
// Purpose : Gate sequencer. Latches the requested mode on a card swipe, judges
//           the bookkeeping verdict flags, issues a one-cycle action_taken
//           commit and drives the barrier, offer and deny lamps.
// Revision: 1.0  initial release
// ============================================================================
module parking_gate_ctrl #(
  parameter int OFFER_TIMEOUT = 1000,
  parameter int GATE_TIMEOUT  = 2000,
  parameter int DENY_CYCLES   = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  parking_gate_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EVAL  = 3'd1,
    S_OFFER = 3'd2,
    S_OPEN  = 3'd3,
    S_DENY  = 3'd4
  } state_t;

  localparam logic [1:0]  MODE_ENTER = 2'd0;
  localparam logic [1:0]  ACT_NONE   = 2'd0;
  localparam logic [1:0]  ACT_ALT    = 2'd1;
  localparam logic [1:0]  ACT_CHOSEN = 2'd2;
  localparam logic [1:0]  ACT_EXIT   = 2'd3;
  localparam logic [1:0]  CODE_ID    = 2'd1;
  localparam logic [1:0]  CODE_FULL  = 2'd2;
  localparam logic [1:0]  CODE_MODE  = 2'd3;
  // timer loads are N-1 so that the state lasts exactly N cycles
  localparam logic [15:0] OFFER_LOAD = 16'(OFFER_TIMEOUT - 1);
  localparam logic [15:0] GATE_LOAD  = 16'(GATE_TIMEOUT - 1);
  localparam logic [15:0] DENY_LOAD  = 16'(DENY_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [1:0]  action_q, action_d;
  logic        gate_q, gate_d;
  logic        offer_q, offer_d;
  logic        deny_q, deny_d;
  logic [1:0]  code_q, code_d;
  logic        busy_q, busy_d;
  logic [15:0] timer_q, timer_d;

  // per-cycle decision, applied to the registers below
  logic        go_open, go_offer, go_deny, go_idle;
  logic [1:0]  act_sel, code_sel;

  // Next-state and registered-output logic: the case picks a destination,
  // the trailing block sets up the outputs belonging to that destination.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    action_d = ACT_NONE;
    gate_d   = gate_q;
    offer_d  = offer_q;
    deny_d   = deny_q;
    code_d   = code_q;
    timer_d  = timer_q;
    go_open  = 1'b0;
    go_offer = 1'b0;
    go_deny  = 1'b0;
    go_idle  = 1'b0;
    act_sel  = ACT_NONE;
    code_sel = 2'd0;

    case (state_q)
      S_IDLE: begin
        if (bus.card_swiped) begin
          if (!bus.mode_sel[1]) begin
            state_d = S_EVAL;
            mode_d  = bus.mode_sel;
          end else begin
            go_deny  = 1'b1;
            code_sel = CODE_MODE;
          end
        end
      end
      S_EVAL: begin
        // flags are combinational on the mode latched one cycle earlier
        if (mode_q == MODE_ENTER) begin
          if (bus.id_special) begin
            go_open = 1'b1;
            act_sel = ACT_NONE;
          end else if (!bus.id_valid) begin
            go_deny  = 1'b1;
            code_sel = CODE_ID;
          end else if (!bus.chosen_flr_full) begin
            go_open = 1'b1;
            act_sel = ACT_CHOSEN;
          end else if (!bus.alternative_flr_full) begin
            go_offer = 1'b1;
          end else begin
            go_deny  = 1'b1;
            code_sel = CODE_FULL;
          end
        end else begin
          if (bus.id_valid) begin
            go_open = 1'b1;
            act_sel = ACT_EXIT;
          end else if (bus.id_special) begin
            go_open = 1'b1;
            act_sel = ACT_NONE;
          end else begin
            go_deny  = 1'b1;
            code_sel = CODE_ID;
          end
        end
      end
      S_OFFER: begin
        // cancel beats accept when both buttons are seen together
        if (bus.reject) begin
          go_idle = 1'b1;
        end else if (bus.accept_alt && bus.alternative_flr_full) begin
          go_deny  = 1'b1;
          code_sel = CODE_FULL;
        end else if (bus.accept_alt) begin
          go_open = 1'b1;
          act_sel = ACT_ALT;
        end else if (timer_q == 16'd0) begin
          go_idle = 1'b1;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_OPEN: begin
        if (bus.car_passed || timer_q == 16'd0) begin
          go_idle = 1'b1;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_DENY: begin
        if (timer_q == 16'd0) begin
          go_idle = 1'b1;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (go_open) begin
      state_d  = S_OPEN;
      action_d = act_sel;
      gate_d   = 1'b1;
      offer_d  = 1'b0;
      timer_d  = GATE_LOAD;
    end
    if (go_offer) begin
      state_d = S_OFFER;
      offer_d = 1'b1;
      timer_d = OFFER_LOAD;
    end
    if (go_deny) begin
      state_d = S_DENY;
      deny_d  = 1'b1;
      code_d  = code_sel;
      offer_d = 1'b0;
      timer_d = DENY_LOAD;
    end
    if (go_idle) begin
      state_d = S_IDLE;
      gate_d  = 1'b0;
      offer_d = 1'b0;
      deny_d  = 1'b0;
      code_d  = 2'd0;
      timer_d = 16'd0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State, timer and output registers; reset aborts any sequence without a commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= 2'd0;
      action_q <= ACT_NONE;
      gate_q   <= 1'b0;
      offer_q  <= 1'b0;
      deny_q   <= 1'b0;
      code_q   <= 2'd0;
      busy_q   <= 1'b0;
      timer_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      action_q <= action_d;
      gate_q   <= gate_d;
      offer_q  <= offer_d;
      deny_q   <= deny_d;
      code_q   <= code_d;
      busy_q   <= busy_d;
      timer_q  <= timer_d;
    end
  end

  assign bus.mode         = mode_q;
  assign bus.action_taken = action_q;
  assign bus.gate_open    = gate_q;
  assign bus.alt_offer    = offer_q;
  assign bus.deny         = deny_q;
  assign bus.deny_code    = code_q;
  assign bus.busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_parking_gate_ctrl
// Purpose : Self-checking bench for parking_gate_ctrl. Each transaction is
//           turned into a schedule of phases (eval/offer/open/deny/idle) from
//           the gate rules; the expected output word per cycle follows from
//           the phase and its position.
// Revision: 1.0  initial release
// ============================================================================
module tb_parking_gate_ctrl;

  localparam int OT = 20;  // offer timeout
  localparam int GT = 15;  // gate timeout
  localparam int DC = 7;   // deny cycles

  localparam int K_EVAL = 0, K_OFFER = 1, K_OPEN = 2, K_DENY = 3, K_IDLE = 4;
  localparam int E_TIMER = 0, E_CAR = 1, E_ACC = 2, E_REJ = 3, E_BOTH = 4;

  typedef struct {
    int kind;
    int len;
    int val;     // action for open phases, code for deny phases
    int end_by;  // what the bench drives on the phase's last cycle
  } seg_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [1:0]  model_mode = 2'd0;
  seg_t        segs[$];
  logic [9:0]  exp_q[$];
  logic [9:0]  obs_q[$];

  parking_gate_ctrl_if bus();

  parking_gate_ctrl #(
    .OFFER_TIMEOUT(OT),
    .GATE_TIMEOUT (GT),
    .DENY_CYCLES  (DC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {mode, action_taken, gate_open, alt_offer, deny, deny_code, busy}
  function automatic logic [9:0] sample_out();
    return {bus.mode, bus.action_taken, bus.gate_open, bus.alt_offer,
            bus.deny, bus.deny_code, bus.busy};
  endfunction

  function automatic logic [9:0] exp_vec(input seg_t sg, input int i);
    logic [1:0] act, code;
    logic g, o, d, b;
    act = 2'd0; code = 2'd0; g = 1'b0; o = 1'b0; d = 1'b0; b = 1'b1;
    case (sg.kind)
      K_OPEN:  begin g = 1'b1; if (i == 0) act = 2'(sg.val); end
      K_OFFER: o = 1'b1;
      K_DENY:  begin d = 1'b1; code = 2'(sg.val); end
      K_IDLE:  b = 1'b0;
      default: ;
    endcase
    return {model_mode, act, g, o, d, code, b};
  endfunction

  task automatic push_seg(input int kind, input int len, input int val, input int end_by);
    seg_t s;
    s.kind = kind; s.len = len; s.val = val; s.end_by = end_by;
    segs.push_back(s);
  endtask

  task automatic push_open(input int act, input int car_at);
    if (car_at >= 0 && car_at < GT) push_seg(K_OPEN, car_at + 1, act, E_CAR);
    else                            push_seg(K_OPEN, GT, act, E_TIMER);
  endtask

  // Reference model: what the gate must do for one swipe, as a phase list
  task automatic build_schedule(input int msel, input bit v, input bit s, input bit cf,
                                input bit af, input int ans, input int ans_at,
                                input bit af_acc, input int car_at);
    if (msel >= 2) begin
      push_seg(K_DENY, DC, 3, E_TIMER);
    end else begin
      model_mode = 2'(msel);
      push_seg(K_EVAL, 1, 0, E_TIMER);
      if (msel == 0) begin
        if (s)        push_open(0, car_at);
        else if (!v)  push_seg(K_DENY, DC, 1, E_TIMER);
        else if (!cf) push_open(2, car_at);
        else if (!af) begin
          if (ans == 0 || ans_at >= OT) begin
            push_seg(K_OFFER, OT, 0, E_TIMER);
          end else begin
            push_seg(K_OFFER, ans_at + 1, 0,
                     (ans == 1) ? E_ACC : (ans == 2) ? E_REJ : E_BOTH);
            if (ans == 1) begin
              if (af_acc) push_seg(K_DENY, DC, 2, E_TIMER);
              else        push_open(1, car_at);
            end
          end
        end else        push_seg(K_DENY, DC, 2, E_TIMER);
      end else begin
        if (v)      push_open(3, car_at);
        else if (s) push_open(0, car_at);
        else        push_seg(K_DENY, DC, 1, E_TIMER);
      end
    end
    push_seg(K_IDLE, 1, 0, E_TIMER);
  endtask

  // Swipe from IDLE, then walk the schedule recording observed/expected words
  task automatic play_txn(input int msel, input bit v, input bit s, input bit cf,
                          input bit af, input int ans, input int ans_at,
                          input bit af_acc, input int car_at, input bit noise);
    seg_t sg;
    segs.delete();
    build_schedule(msel, v, s, cf, af, ans, ans_at, af_acc, car_at);
    bus.card_swiped = 1'b1;
    bus.mode_sel = 2'(msel);
    bus.id_valid = v;
    bus.id_special = s;
    bus.chosen_flr_full = cf;
    bus.alternative_flr_full = af;
    bus.accept_alt = 1'b0;
    bus.reject = 1'b0;
    bus.car_passed = 1'b0;
    foreach (segs[j]) begin
      sg = segs[j];
      for (int i = 0; i < sg.len; i++) begin
        step();
        obs_q.push_back(sample_out());
        exp_q.push_back(exp_vec(sg, i));
        bus.card_swiped = noise && (sg.kind != K_IDLE) && ($urandom_range(0, 3) == 0);
        bus.mode_sel = 2'($urandom_range(0, 3));
        bus.accept_alt = 1'b0;
        bus.reject = 1'b0;
        bus.car_passed = 1'b0;
        if (i == sg.len - 1) begin
          case (sg.end_by)
            E_CAR:  bus.car_passed = 1'b1;
            E_ACC:  begin bus.accept_alt = 1'b1; bus.alternative_flr_full = af_acc; end
            E_REJ:  bus.reject = 1'b1;
            E_BOTH: begin bus.reject = 1'b1; bus.accept_alt = 1'b1; end
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [9:0] o;
    bus.card_swiped = 1'b0; bus.mode_sel = 2'd0; bus.id_valid = 1'b0;
    bus.id_special = 1'b0; bus.chosen_flr_full = 1'b0; bus.alternative_flr_full = 1'b0;
    bus.accept_alt = 1'b0; bus.reject = 1'b0; bus.car_passed = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    o = sample_out();
    checks++;
    if (o !== 10'd0) begin
      failures++;
      $display("FAIL reset_hold got=%b exp=%b", o, 10'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      o = sample_out();
      checks++;
      if (o !== 10'd0) begin
        failures++;
        $display("FAIL reset_idle cycle=%0d got=%b exp=%b", i, o, 10'd0);
      end
    end
  endtask

  task automatic test_enter_open();
    exp_q.delete(); obs_q.delete();
    play_txn(0, 1, 0, 0, 0, 0, 0, 0, 5, 1);   // car 5 cycles after the commit
    play_txn(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);   // car during the first open cycle
    play_txn(0, 0, 1, 1, 1, 0, 0, 0, 3, 0);   // special user, no commit
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL enter_open cycle=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_offer();
    exp_q.delete(); obs_q.delete();
    play_txn(0, 1, 0, 1, 0, 1, 9, 0, 2, 1);      // accept at the 10th offer cycle
    play_txn(0, 1, 0, 1, 0, 4, 3, 0, -1, 0);     // reject+accept together
    play_txn(0, 1, 0, 1, 0, 2, 0, 0, -1, 0);     // reject on first offer cycle
    play_txn(0, 1, 0, 1, 0, 1, OT - 1, 1, -1, 0);// accept on last cycle, alt now full
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL offer cycle=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_deny();
    exp_q.delete(); obs_q.delete();
    play_txn(0, 1, 0, 1, 1, 0, 0, 0, -1, 1);  // both floors full
    play_txn(2, 1, 0, 0, 0, 0, 0, 0, -1, 1);  // illegal mode 2
    play_txn(3, 1, 0, 0, 0, 0, 0, 0, -1, 0);  // illegal mode 3
    play_txn(0, 0, 0, 0, 0, 0, 0, 0, -1, 0);  // unknown id on enter
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL deny cycle=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_exit();
    exp_q.delete(); obs_q.delete();
    play_txn(1, 1, 0, 1, 1, 0, 0, 0, 1, 1);   // valid id -> exit commit
    play_txn(1, 0, 0, 0, 0, 0, 0, 0, -1, 0);  // unknown id -> deny code 1
    play_txn(1, 0, 1, 0, 0, 0, 0, 0, 4, 0);   // special -> open, no commit
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL exit cycle=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_timeouts();
    exp_q.delete(); obs_q.delete();
    play_txn(0, 1, 0, 1, 0, 0, 0, 0, -1, 1);  // offer never answered
    play_txn(0, 1, 0, 0, 0, 0, 0, 0, -1, 1);  // gate open, car never passes
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL timeouts cycle=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [9:0] o;
    bus.card_swiped = 1'b1; bus.mode_sel = 2'd0; bus.id_valid = 1'b1;
    bus.id_special = 1'b0; bus.chosen_flr_full = 1'b1; bus.alternative_flr_full = 1'b0;
    step();
    bus.card_swiped = 1'b0;
    repeat (3) step();
    o = sample_out();
    checks++;
    if (o !== {2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1}) begin
      failures++;
      $display("FAIL abort_offer got=%b exp=%b", o, {2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1});
    end
    #3 rst_n = 1'b0;
    bus.accept_alt = 1'b1;
    #1;
    o = sample_out();
    checks++;
    if (o !== 10'd0) begin
      failures++;
      $display("FAIL abort_immediate got=%b exp=%b", o, 10'd0);
    end
    #2 rst_n = 1'b1;
    bus.accept_alt = 1'b0;
    model_mode = 2'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      o = sample_out();
      checks++;
      if (o !== 10'd0) begin
        failures++;
        $display("FAIL abort_after cycle=%0d got=%b exp=%b", i, o, 10'd0);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_q.delete(); obs_q.delete();
    play_txn(0, 1, 0, 0, 0, 0, 0, 0, 2, 1);
    play_txn(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    play_txn(3, 0, 0, 0, 0, 0, 0, 0, -1, 1);
    play_txn(0, 1, 0, 1, 0, 1, 2, 0, 1, 1);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL back_to_back cycle=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int msel, ans, ans_at, car_at;
    bit v, s, cf, af, af_acc;
    exp_q.delete(); obs_q.delete();
    for (int n = 0; n < 40; n++) begin
      msel   = ($urandom_range(0, 7) == 0) ? 2 + int'($urandom_range(0, 1))
                                           : int'($urandom_range(0, 1));
      v      = 1'($urandom_range(0, 1));
      s      = ($urandom_range(0, 3) == 0);
      cf     = 1'($urandom_range(0, 1));
      af     = 1'($urandom_range(0, 1));
      ans    = int'($urandom_range(0, 3));
      ans_at = int'($urandom_range(0, OT + 2));
      af_acc = ($urandom_range(0, 3) == 0);
      car_at = int'($urandom_range(0, GT + 3)) - 1;
      play_txn(msel, v, s, cf, af, ans, ans_at, af_acc, car_at, 1'b1);
    end
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL random cycle=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_enter_open();
    test_offer();
    test_deny();
    test_exit();
    test_timeouts();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
